// File: rtl/event_blinker.sv
// Turns short event pulses into LED blinks of fixed on-time and minimum off-gap.
// Define EVENT_BLINKER_SYNC_EN to add a two-flop input synchronizer for asynchronous event sources.
module event_blinker #(
  parameter int c_ON_CYCLES   = 2500000,
  parameter int c_OFF_CYCLES  = 2500000,
  parameter int c_MAX_PENDING = 7
) (
  input  logic                                   i_Clk,
  input  logic                                   i_Rst_L,
  input  logic                                   i_Event,
  output logic                                   o_LED,
  output logic                                   o_Busy,
  output logic [$clog2(c_MAX_PENDING+1)-1:0]     o_Pending,
  output logic                                   o_Overflow
);

  localparam int c_PEND_W  = $clog2(c_MAX_PENDING + 1);
  localparam int c_CNT_MAX = (c_ON_CYCLES > c_OFF_CYCLES) ? c_ON_CYCLES : c_OFF_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0]  c_ON_LAST  = c_CNT_W'(c_ON_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_OFF_LAST = c_CNT_W'(c_OFF_CYCLES - 1);
  localparam logic [c_PEND_W-1:0] c_PEND_SAT = c_PEND_W'(c_MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_reg;
  logic [c_CNT_W-1:0]    cnt_reg;
  logic [c_PEND_W-1:0]   pending_reg;
  logic [c_PEND_W-1:0]   pending_next;
  logic                  event_prev_reg;
  logic                  overflow_reg;
  logic                  led_reg;
  logic                  busy_reg;
  logic                  event_s;
  logic                  event_edge;
  logic                  on_done;
  logic                  gap_done;
  logic                  start;
  logic                  overflow_set;

`ifdef EVENT_BLINKER_SYNC_EN
  // Both stages reset high so a source already high at reset release is not seen as an edge.
  logic [1:0] sync_reg;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_Event};
    end
  end

  assign event_s = sync_reg[1];
`else
  assign event_s = i_Event;
`endif

  always_comb begin
    event_edge   = event_s & ~event_prev_reg;
    on_done      = (state_reg == ON)  && (cnt_reg == c_ON_LAST);
    gap_done     = (state_reg == GAP) && (cnt_reg == c_OFF_LAST);
    start        = (pending_reg != '0) && ((state_reg == IDLE) || gap_done);
    pending_next = pending_reg;
    overflow_set = 1'b0;
    // A saturated counter drops the new event; a start on the same edge still consumes one.
    if (event_edge && (pending_reg == c_PEND_SAT)) begin
      overflow_set = 1'b1;
      if (start) begin
        pending_next = pending_reg - c_PEND_W'(1);
      end
    end else if (event_edge && !start) begin
      pending_next = pending_reg + c_PEND_W'(1);
    end else if (!event_edge && start) begin
      pending_next = pending_reg - c_PEND_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pending_reg    <= '0;
      event_prev_reg <= 1'b1;
      overflow_reg   <= 1'b0;
      led_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      event_prev_reg <= event_s;
      pending_reg    <= pending_next;
      overflow_reg   <= overflow_reg | overflow_set;
      busy_reg       <= 1'b1;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (start) begin
            state_reg <= ON;
            led_reg   <= 1'b1;
          end else begin
            led_reg  <= 1'b0;
            busy_reg <= (pending_next != '0);
          end
        end
        ON: begin
          if (on_done) begin
            state_reg <= GAP;
            cnt_reg   <= '0;
            led_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + c_CNT_W'(1);
            led_reg <= 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            cnt_reg <= '0;
            if (start) begin
              state_reg <= ON;
              led_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
              led_reg   <= 1'b0;
              busy_reg  <= (pending_next != '0);
            end
          end else begin
            cnt_reg <= cnt_reg + c_CNT_W'(1);
            led_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          led_reg   <= 1'b0;
          busy_reg  <= (pending_next != '0);
        end
      endcase
    end
  end

  assign o_LED      = led_reg;
  assign o_Busy     = busy_reg;
  assign o_Pending  = pending_reg;
  assign o_Overflow = overflow_reg;

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker: time-based reference model checked every cycle, plus directed literal checks.
module tb_event_blinker;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;
  localparam int PER  = ON + OFF;

  logic       i_Clk   = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Event = 1'b0;
  logic       o_LED;
  logic       o_Busy;
  logic       o_Overflow;
  logic [1:0] o_Pending;

  always #5 i_Clk = ~i_Clk;

  event_blinker #(
    .c_ON_CYCLES  (ON),
    .c_OFF_CYCLES (OFF),
    .c_MAX_PENDING(MAXP)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Event   (i_Event),
    .o_LED     (o_LED),
    .o_Busy    (o_Busy),
    .o_Pending (o_Pending),
    .o_Overflow(o_Overflow)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int t0     = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, local edge %0d)",
                  name, act, exp, cyc, cyc - t0);
  endtask

  // Reference model: a blink may start whenever something is queued and
  // at least one full on+off period has elapsed since the previous start.
  int m_pend;
  int m_last;
  bit m_ovf, m_prev, m_led, m_busy, m_valid = 1'b0;

  always @(posedge i_Clk) begin
    bit ev, st;
    cyc++;
    if (!i_Rst_L) begin
      m_pend = 0; m_ovf = 0; m_last = -1000; m_prev = 1;
      m_led = 0; m_busy = 0; m_valid = 1;
    end else begin
      ev = i_Event && !m_prev;
      m_prev = i_Event;
      st = (m_pend > 0) && (cyc >= m_last + PER);
      if (st) m_last = cyc;
      if (ev && m_pend == MAXP) begin
        m_ovf = 1;
        m_pend = m_pend - int'(st);
      end else begin
        m_pend = m_pend + int'(ev) - int'(st);
      end
      m_led  = (cyc - m_last) < ON;
      m_busy = ((cyc - m_last) < PER) || (m_pend > 0);
    end
  end

  int rises = 0;
  int pend_gt1 = 0;
  bit prev_led = 1'b0;

  always @(negedge i_Clk) begin
    if (m_valid) begin
      chk("model_led",      int'(o_LED),      int'(m_led));
      chk("model_busy",     int'(o_Busy),     int'(m_busy));
      chk("model_pending",  int'(o_Pending),  m_pend);
      chk("model_overflow", int'(o_Overflow), int'(m_ovf));
      if (o_LED && !prev_led) rises++;
      if (o_Pending > 2'd1) pend_gt1++;
      prev_led = o_LED;
    end
  end

  // Returns just after the falling edge following local edge e.
  task automatic at_edge(input int e);
    while (cyc < t0 + e) @(negedge i_Clk);
    #1;
  endtask

  task automatic pulse(input int k);
    at_edge(k - 1);
    i_Event = 1'b1;
    at_edge(k);
    i_Event = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    repeat (2) @(negedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0, g0;

    // Reset state
    do_reset();
    chk("rst_led", int'(o_LED), 0);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_pending", int'(o_Pending), 0);
    chk("rst_overflow", int'(o_Overflow), 0);

    // 1: single pulse
    r0 = rises;
    pulse(10);
    chk("t1_pend_10", int'(o_Pending), 1);
    chk("t1_led_10", int'(o_LED), 0);
    at_edge(11); chk("t1_led_11", int'(o_LED), 1); chk("t1_pend_11", int'(o_Pending), 0);
    at_edge(14); chk("t1_led_14", int'(o_LED), 1);
    at_edge(15); chk("t1_led_15", int'(o_LED), 0); chk("t1_busy_15", int'(o_Busy), 1);
    at_edge(17); chk("t1_busy_17", int'(o_Busy), 1);
    at_edge(18); chk("t1_busy_18", int'(o_Busy), 0);
    chk("t1_blinks", rises - r0, 1);

    // 2: three spaced pulses
    do_reset();
    r0 = rises;
    pulse(10);
    at_edge(11); chk("t2_led_11", int'(o_LED), 1);
    pulse(12);
    pulse(14); chk("t2_pend_14", int'(o_Pending), 2);
    at_edge(17); chk("t2_led_17", int'(o_LED), 0);
    at_edge(18); chk("t2_led_18", int'(o_LED), 1); chk("t2_pend_18", int'(o_Pending), 1);
    at_edge(24); chk("t2_led_24", int'(o_LED), 0);
    at_edge(25); chk("t2_led_25", int'(o_LED), 1); chk("t2_pend_25", int'(o_Pending), 0);
    at_edge(32); chk("t2_busy_32", int'(o_Busy), 0);
    at_edge(40); chk("t2_ovf", int'(o_Overflow), 0); chk("t2_blinks", rises - r0, 3);

    // 3: saturation and overflow
    do_reset();
    r0 = rises;
    pulse(10); pulse(12); pulse(14); pulse(16);
    chk("t3_pend_16", int'(o_Pending), 3);
    chk("t3_ovf_16", int'(o_Overflow), 0);
    pulse(18);
    chk("t3_ovf_18", int'(o_Overflow), 1);
    chk("t3_pend_18", int'(o_Pending), 2);
    at_edge(45);
    chk("t3_ovf_45", int'(o_Overflow), 1);
    chk("t3_busy_45", int'(o_Busy), 0);
    chk("t3_blinks", rises - r0, 4);

    // 4: level held high counts once
    do_reset();
    r0 = rises; g0 = pend_gt1;
    at_edge(9); i_Event = 1'b1;
    at_edge(10); chk("t4_pend_10", int'(o_Pending), 1);
    at_edge(29); i_Event = 1'b0;
    at_edge(50);
    chk("t4_blinks", rises - r0, 1);
    chk("t4_pend_gt1", pend_gt1 - g0, 0);
    chk("t4_busy_50", int'(o_Busy), 0);

    // 5: reset during ON with two queued, event held through release
    do_reset();
    r0 = rises;
    pulse(10); pulse(12); pulse(14);
    chk("t5_led_14", int'(o_LED), 1);
    chk("t5_pend_14", int'(o_Pending), 2);
    i_Rst_L = 1'b0;
    i_Event = 1'b1;
    at_edge(15);
    chk("t5_led_rst", int'(o_LED), 0);
    chk("t5_pend_rst", int'(o_Pending), 0);
    chk("t5_ovf_rst", int'(o_Overflow), 0);
    chk("t5_busy_rst", int'(o_Busy), 0);
    at_edge(16);
    i_Rst_L = 1'b1;
    t0 = cyc;
    r0 = rises;
    at_edge(20);
    chk("t5_pend_rel", int'(o_Pending), 0);
    i_Event = 1'b0;
    at_edge(30);
    chk("t5_blinks", rises - r0, 0);
    chk("t5_led_30", int'(o_LED), 0);

    // 6: new event on the edge GAP completes with one queued
    do_reset();
    r0 = rises;
    pulse(10); pulse(12);
    at_edge(17); chk("t6_pend_17", int'(o_Pending), 1); chk("t6_led_17", int'(o_LED), 0);
    pulse(18);
    chk("t6_pend_18", int'(o_Pending), 1);
    chk("t6_led_18", int'(o_LED), 1);
    at_edge(25); chk("t6_led_25", int'(o_LED), 1); chk("t6_pend_25", int'(o_Pending), 0);
    at_edge(45); chk("t6_blinks", rises - r0, 3); chk("t6_busy_45", int'(o_Busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Output-side counterpart of the switch debouncer: converts short internal event pulses into human-visible LED blinks.
- Each rising edge on the event input queues one blink. Blinks are emitted one at a time with a guaranteed minimum on-time and off-gap.
- Sits between control logic (button handlers, UART byte strobes, error flags) and a board LED pin.

Parameters:
c_ON_CYCLES, 2500000, LED on-time per blink in clock cycles (100 ms at 25 MHz); must be >= 1
c_OFF_CYCLES, 2500000, minimum LED off-gap after each blink in clock cycles; must be >= 1
c_MAX_PENDING, 7, saturation limit of the queued-blink counter; must be >= 1

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  synchronous active-low reset
i_Event  input  1  event request; each 0->1 transition queues one blink
o_LED  output  1  LED drive, active-high, registered
o_Busy  output  1  high when state != IDLE or pending count > 0
o_Pending  output  $clog2(c_MAX_PENDING+1)  queued blinks not yet started
o_Overflow  output  1  sticky; set when an event arrives while pending == c_MAX_PENDING

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous and active-low (i_Rst_L sampled on posedge i_Clk).
- Reset values: o_LED=0, o_Busy=0, o_Pending=0, o_Overflow=0, state=IDLE, cycle counter=0, r_Event_Prev=1.
  - r_Event_Prev=1 means an i_Event held high across reset release does not produce an event.
- Reset mid-operation aborts any blink immediately; all outputs take reset values on that edge.
- Edge detect: edge = i_Event & ~r_Event_Prev, evaluated combinationally. r_Event_Prev <= i_Event every clock.
  - A level held high counts once.
- Pending counter update per clock:
  - edge and no start: +1, saturating at c_MAX_PENDING.
  - start and no edge: -1.
  - edge and start on the same edge: unchanged.
  - edge while saturated and no start: count unchanged, o_Overflow <= 1. o_Overflow clears only on reset.
- Cycle counter width: $clog2(max(c_ON_CYCLES,c_OFF_CYCLES)+1). It is cleared on every state entry.
- FSM:
  - IDLE: if pending > 0, go to ON (start). o_LED=0.
  - ON: o_LED=1. Count c_ON_CYCLES cycles, then go to GAP.
  - GAP: o_LED=0. Count c_OFF_CYCLES cycles, then go to ON if pending > 0 (start), else IDLE.
- "start" means the clock edge on which the FSM enters ON; pending decrements on that edge.
- Timing:
  - i_Event first sampled high at edge k: pending=1 after k; ON entered and o_LED=1 after k+1.
  - o_LED high for exactly c_ON_CYCLES cycles, then low for at least c_OFF_CYCLES cycles.
  - Back-to-back blinks have period c_ON_CYCLES+c_OFF_CYCLES with no extra IDLE cycle.
- Events arriving during ON or GAP are queued, never dropped, unless the counter is saturated.
- o_Busy is registered-consistent with state and pending (no combinational path from i_Event).

Optional Feature:
- Macro: EVENT_BLINKER_SYNC_EN.
- Defined: i_Event passes through a two-flop synchronizer (both flops reset to 1) before edge detect. This allows asynchronous sources such as raw pins. Event-to-LED latency grows by 2 cycles (LED high after edge k+3).
- Undefined: i_Event is assumed synchronous to i_Clk and feeds edge detect directly, with the latency above.

Test Plan:
All tests use c_ON_CYCLES=4, c_OFF_CYCLES=3, c_MAX_PENDING=3, macro undefined.
1. Single 1-cycle pulse sampled at edge 10 -> o_Pending=1 after 10, o_LED=1 after edges 11..14, o_LED=0 after 15, IDLE and o_Busy=0 after edge 18.
2. Pulses at edges 10, 12, 14 -> o_Pending peaks at 2; three blinks with LED rising after edges 11, 18, 25; o_Overflow stays 0.
3. Pulses at edges 10, 12, 14, 16, 18 -> o_Pending saturates at 3, o_Overflow=1 after edge 18 and stays set; exactly 4 blinks emitted.
4. i_Event held high for 20 cycles from edge 10 -> exactly one blink; o_Pending never exceeds 1.
5. Reset asserted during ON with o_Pending=2 -> next edge o_LED=0, o_Pending=0, o_Overflow=0; i_Event high through reset release -> no blink.
6. New pulse on the same edge GAP completes with o_Pending=1 -> o_Pending stays 1, ON entered on that edge, a further blink follows.
